// File: rtl/csr_regs_pkg.sv
// Machine-mode CSR addresses and WARL write masks.
package csr_regs_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MCNTINH  = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MINSTRH  = 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRH   = 12'hC82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] MCNTINH_WMASK = 32'h0000_0005;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with inhibit and per-half write.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        inhibit,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // A write freezes the untouched half: no increment, no carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (we_lo || we_hi) begin
      if (we_lo) count[31:0]  <= wdata;
      if (we_hi) count[63:32] <= wdata;
    end else if (inc && !inhibit) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_regs.sv
// Machine-mode CSR file: read port to id, writes from ex,
// trap/mret state updates, counters and interrupt pending.
module csr_regs
  import csr_regs_pkg::*;
#(
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_addr_i,
  output logic [31:0] csr_data_o,
  output logic        csr_ill_o,
  input  logic        we_i,
  input  logic [11:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        instret_i,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_val_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_tmr_i,
  input  logic        irq_sw_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pend_o
);

  logic        st_mie;
  logic        st_mpie;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mcntinh_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic [31:0] mstatus;
  logic [31:0] mip;

  assign mstatus = {19'b0, 2'b11, 3'b0, st_mpie,
                    3'b0, st_mie, 3'b0};
  assign mip = {20'b0, irq_ext_i, 3'b0, irq_tmr_i,
                3'b0, irq_sw_i, 3'b0};

  // trap/mret own mstatus, mepc, mcause and mtval this cycle
  logic lock;
  assign lock = trap_i | mret_i;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mcntinh;
  logic wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
  logic wr_reg;

  assign wr_mstatus  = we_i & ~lock & (waddr_i == CSR_MSTATUS);
  assign wr_mie      = we_i & (waddr_i == CSR_MIE);
  assign wr_mtvec    = we_i & (waddr_i == CSR_MTVEC);
  assign wr_mcntinh  = we_i & (waddr_i == CSR_MCNTINH);
  assign wr_mscratch = we_i & (waddr_i == CSR_MSCRATCH);
  assign wr_mepc     = we_i & ~lock & (waddr_i == CSR_MEPC);
  assign wr_mcause   = we_i & ~lock & (waddr_i == CSR_MCAUSE);
  assign wr_mtval    = we_i & ~lock & (waddr_i == CSR_MTVAL);
  assign wr_cyc_lo   = we_i & (waddr_i == CSR_MCYCLE);
  assign wr_cyc_hi   = we_i & (waddr_i == CSR_MCYCLEH);
  assign wr_ins_lo   = we_i & (waddr_i == CSR_MINSTRET);
  assign wr_ins_hi   = we_i & (waddr_i == CSR_MINSTRH);

  assign wr_reg = wr_mstatus | wr_mie | wr_mtvec | wr_mcntinh |
                  wr_mscratch | wr_mepc | wr_mcause | wr_mtval;

  logic [31:0] wval;
  always_comb begin
    wval = wdata_i;
    case (waddr_i)
      CSR_MSTATUS:
        wval = (wdata_i & MSTATUS_WMASK) | MSTATUS_FIXED;
      CSR_MIE:     wval = wdata_i & MIE_WMASK;
      CSR_MTVEC:   wval = wdata_i & MTVEC_WMASK;
      CSR_MEPC:    wval = wdata_i & MEPC_WMASK;
      CSR_MCNTINH: wval = wdata_i & MCNTINH_WMASK;
      default:     wval = wdata_i;
    endcase
  end

  logic [31:0] rdata;
  always_comb begin
    rdata     = '0;
    csr_ill_o = 1'b0;
    case (csr_addr_i)
      CSR_MSTATUS:  rdata = mstatus;
      CSR_MISA:     rdata = MISA_VAL;
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MCNTINH:  rdata = mcntinh_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MIP:      rdata = mip;
      CSR_MCYCLE,
      CSR_CYCLE:    rdata = mcycle[31:0];
      CSR_MCYCLEH,
      CSR_CYCLEH:   rdata = mcycle[63:32];
      CSR_MINSTRET,
      CSR_INSTRET:  rdata = minstret[31:0];
      CSR_MINSTRH,
      CSR_INSTRH:   rdata = minstret[63:32];
      CSR_MHARTID:  rdata = HART_ID;
      default:      csr_ill_o = 1'b1;
    endcase
  end

  // Counters are excluded from bypass: they show the pre-write value.
  assign csr_data_o = (wr_reg && waddr_i == csr_addr_i) ?
                      wval : rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mcntinh_q  <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (trap_i) begin
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
        mepc_q   <= trap_pc_i & MEPC_WMASK;
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_val_i;
      end else if (mret_i) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else begin
        if (wr_mstatus) begin
          st_mie  <= wval[3];
          st_mpie <= wval[7];
        end
        if (wr_mepc)   mepc_q   <= wval;
        if (wr_mcause) mcause_q <= wval;
        if (wr_mtval)  mtval_q  <= wval;
      end
      if (wr_mie)      mie_q      <= wval;
      if (wr_mtvec)    mtvec_q    <= wval;
      if (wr_mcntinh)  mcntinh_q  <= wval;
      if (wr_mscratch) mscratch_q <= wval;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (1'b1),
    .inhibit (mcntinh_q[0]),
    .we_lo   (wr_cyc_lo),
    .we_hi   (wr_cyc_hi),
    .wdata   (wdata_i),
    .count   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (instret_i),
    .inhibit (mcntinh_q[2]),
    .we_lo   (wr_ins_lo),
    .we_hi   (wr_ins_hi),
    .wdata   (wdata_i),
    .count   (minstret)
  );

  assign mtvec_o    = mtvec_q;
  assign mepc_o     = mepc_q;
  assign irq_pend_o = st_mie & |(mie_q & mip);

endmodule

// File: tb/tb_csr_regs.sv
// Directed bench for csr_regs: per-cycle vector table plus
// hand sequences for trap, mret, interrupts and async reset.
module tb_csr_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_data_o;
  logic        csr_ill_o;
  logic        we_i;
  logic [11:0] waddr_i;
  logic [31:0] wdata_i;
  logic        instret_i;
  logic        trap_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_val_i;
  logic        mret_i;
  logic        irq_ext_i;
  logic        irq_tmr_i;
  logic        irq_sw_i;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        irq_pend_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csr_regs #(
    .HART_ID   (32'h7),
    .MISA_VAL  (32'h4000_0100),
    .MTVEC_RST (32'h0000_0100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_addr_i   (csr_addr_i),
    .csr_data_o   (csr_data_o),
    .csr_ill_o    (csr_ill_o),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .instret_i    (instret_i),
    .trap_i       (trap_i),
    .trap_cause_i (trap_cause_i),
    .trap_pc_i    (trap_pc_i),
    .trap_val_i   (trap_val_i),
    .mret_i       (mret_i),
    .irq_ext_i    (irq_ext_i),
    .irq_tmr_i    (irq_tmr_i),
    .irq_sw_i     (irq_sw_i),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .irq_pend_o   (irq_pend_o)
  );

  typedef struct {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        instret;
    logic [11:0] raddr;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic we, logic [11:0] wa,
                              logic [31:0] wd, logic ir,
                              logic [11:0] ra, logic [31:0] ex,
                              logic il);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd; v.instret = ir;
    v.raddr = ra; v.exp = ex; v.ill = il;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    instret_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
    trap_cause_i = '0; trap_pc_i = '0; trap_val_i = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
  endtask

  task automatic rd(input string name, input logic [11:0] a,
                    input logic [31:0] exp);
    csr_addr_i = a;
    #1;
    chk(name, csr_data_o, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    irq_ext_i = 1'b0; irq_tmr_i = 1'b0; irq_sw_i = 1'b0;
    csr_addr_i = 12'h300;
    idle();

    tbl.push_back(mk(1, 12'h340, 32'hDEAD_BEEF, 0, 12'h340, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'h340, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(1, 12'h300, 32'hFFFF_FFFF, 0, 12'h300, 32'h0000_1888, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'h300, 32'h0000_1888, 0));
    tbl.push_back(mk(1, 12'h341, 32'h0000_1003, 0, 12'h341, 32'h0000_1000, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'h341, 32'h0000_1000, 0));
    tbl.push_back(mk(1, 12'h305, 32'hFFFF_FFFF, 0, 12'h305, 32'hFFFF_FFFD, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'h304, 32'h0, 0));
    tbl.push_back(mk(1, 12'h304, 32'hFFFF_FFFF, 0, 12'h304, 32'h0000_0888, 0));
    tbl.push_back(mk(1, 12'h320, 32'hFFFF_FFFF, 0, 12'h320, 32'h5, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'h320, 32'h5, 0));
    tbl.push_back(mk(1, 12'h301, 32'h1234_5678, 0, 12'h301, 32'h4000_0100, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'hF14, 32'h7, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'h7C0, 32'h0, 1));
    tbl.push_back(mk(1, 12'h7C0, 32'h1, 0, 12'h7C0, 32'h0, 1));
    tbl.push_back(mk(1, 12'h342, 32'hAAAA_5555, 0, 12'h342, 32'hAAAA_5555, 0));
    tbl.push_back(mk(1, 12'h343, 32'h1234_5678, 0, 12'h343, 32'h1234_5678, 0));
    tbl.push_back(mk(1, 12'hF14, 32'h99, 0, 12'hF14, 32'h7, 0));
    tbl.push_back(mk(1, 12'hB00, 32'h100, 0, 12'h344, 32'h0, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'hB00, 32'h100, 0));
    tbl.push_back(mk(1, 12'hB00, 32'h200, 0, 12'hB00, 32'h100, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'hC00, 32'h200, 0));
    tbl.push_back(mk(1, 12'hB80, 32'h7, 0, 12'hB80, 32'h0, 0));
    tbl.push_back(mk(1, 12'hB00, 32'hFFFF_FFFF, 0, 12'hC80, 32'h7, 0));
    tbl.push_back(mk(1, 12'h320, 32'h0, 0, 12'hB00, 32'hFFFF_FFFF, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'hB00, 32'hFFFF_FFFF, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'hB80, 32'h8, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'hC00, 32'h1, 0));
    tbl.push_back(mk(1, 12'hB00, 32'hFFFF_FFFF, 0, 12'hB80, 32'h8, 0));
    tbl.push_back(mk(1, 12'hB00, 32'h5, 0, 12'hB80, 32'h8, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'hB00, 32'h5, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'hB80, 32'h8, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 1, 12'hB02, 32'h0, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 1, 12'hC02, 32'h1, 0));
    tbl.push_back(mk(1, 12'hB02, 32'hA, 1, 12'hB02, 32'h2, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'hB02, 32'hA, 0));
    tbl.push_back(mk(1, 12'h320, 32'hFFFF_FFFC, 0, 12'h320, 32'h4, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 1, 12'hB02, 32'hA, 0));
    tbl.push_back(mk(0, 12'h000, 32'h0, 0, 12'hC02, 32'hA, 0));

    // reset state
    #12;
    chk("rst_mtvec", mtvec_o, 32'h0000_0100);
    chk("rst_mepc", mepc_o, 32'h0);
    chk("rst_pend", {31'b0, irq_pend_o}, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mcycle", 12'hB00, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    next();
    rd("mcycle_1", 12'hB00, 32'h1);
    next();
    rd("mcycle_2", 12'hB00, 32'h2);
    next();

    foreach (tbl[i]) begin
      we_i = tbl[i].we;
      waddr_i = tbl[i].waddr;
      wdata_i = tbl[i].wdata;
      instret_i = tbl[i].instret;
      csr_addr_i = tbl[i].raddr;
      #2;
      chk($sformatf("vec%0d_data", i), csr_data_o, tbl[i].exp);
      chk($sformatf("vec%0d_ill", i), {31'b0, csr_ill_o},
          {31'b0, tbl[i].ill});
      next();
    end
    chk("mtvec_out", mtvec_o, 32'hFFFF_FFFD);

    // trap entry beats a same-cycle mepc write
    wr(12'h300, 32'h8);
    next();
    rd("mst_mie_only", 12'h300, 32'h0000_1808);
    trap_i = 1'b1; trap_cause_i = 32'h8000_000B;
    trap_pc_i = 32'h203; trap_val_i = 32'h55;
    wr(12'h341, 32'h444);
    rd("trap_no_bypass", 12'h341, 32'h0000_1000);
    next();
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    chk("trap_mepc_o", mepc_o, 32'h200);
    next();
    rd("trap_mcause", 12'h342, 32'h8000_000B);
    next();
    rd("trap_mtval", 12'h343, 32'h55);
    next();

    // mret restores MIE; unrelated write still lands
    mret_i = 1'b1;
    wr(12'h340, 32'h1234);
    rd("mret_wr_other", 12'h340, 32'h1234);
    next();
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    next();
    rd("mret_mscratch", 12'h340, 32'h1234);
    next();

    // trap and mret together act as trap
    trap_i = 1'b1; mret_i = 1'b1;
    trap_cause_i = 32'h3; trap_pc_i = 32'h300;
    next();
    rd("both_mstatus", 12'h300, 32'h0000_1880);
    chk("both_mepc_o", mepc_o, 32'h300);
    rd("both_mcause", 12'h342, 32'h3);
    next();

    // interrupt pending
    wr(12'h300, 32'h8);
    next();
    wr(12'h304, 32'h800);
    next();
    irq_ext_i = 1'b1;
    #1;
    chk("pend_ext", {31'b0, irq_pend_o}, 32'h1);
    rd("mip_ext", 12'h344, 32'h800);
    irq_ext_i = 1'b0; irq_tmr_i = 1'b1;
    #1;
    chk("pend_tmr_masked", {31'b0, irq_pend_o}, 32'h0);
    rd("mip_tmr", 12'h344, 32'h80);
    irq_ext_i = 1'b1;
    wr(12'h300, 32'h0);
    #1;
    chk("pend_before_wr", {31'b0, irq_pend_o}, 32'h1);
    next();
    chk("pend_after_wr", {31'b0, irq_pend_o}, 32'h0);
    irq_ext_i = 1'b0; irq_tmr_i = 1'b0;
    next();

    // asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mepc", mepc_o, 32'h0);
    chk("arst_mtvec", mtvec_o, 32'h0000_0100);
    rd("arst_mstatus", 12'h300, 32'h0000_1800);
    rd("arst_mcycle", 12'hB00, 32'h0);
    rd("arst_minstret", 12'hB02, 32'h0);
    rst_n = 1'b1;
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
